// File: rtl/ldpc_enc_cntrl.sv
// ldpc_enc_cntrl
//   Sequencing controller for the small-code LDPC encoder (transmit side).
//   The block works in three phases:
//     1. Load K information bits serially.
//     2. Compute M = N-K parity bits. Each parity bit is the XOR of one
//        parity-generator ROM row ANDed with the info word. One row is
//        processed per cycle. The ROM is external and has a one-cycle
//        read latency.
//     3. Stream the systematic N-bit codeword {parity, info}, bit 0
//        first, under valid/ready flow control.
//
// Optional feature: macro LDPC_ENC_PARALLEL_OUT_EN
//   When defined, the block adds a parallel codeword port (cw) and a
//   cw_valid pulse on the first SEND cycle.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   encode       start request, sampled only in IDLE
//   din          serial information bit
//   din_valid    din qualifier
//   din_ready    high only in LOAD
//   rom_addr     parity-generator row index (0..M-1); holds outside CALC
//   rom_data     ROM row contents, valid the cycle after rom_addr
//   dout         serial codeword bit
//   dout_valid   dout qualifier (SEND)
//   dout_ready   downstream accept
//   dout_last    high with codeword bit N-1
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the final bit transfers
//   number       current bit / row index within the active state
//   cw           (macro only) {parity, info}, held until the next CALC ends
//   cw_valid     (macro only) one-cycle pulse on the first SEND cycle
//
// State | meaning
//   IDLE  | waiting for encode
//   LOAD  | shifting in info bits; number = next info bit index
//   CALC  | ROM walk; number = cycle index 0..M
//   SEND  | streaming codeword; number = bit being offered
module ldpc_enc_cntrl #(
  parameter int N = 21,
  parameter int K = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         encode,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [4:0]   rom_addr,
  input  logic [K-1:0] rom_data,
  output logic         dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last,
  output logic         busy,
  output logic         done,
  output logic [4:0]   number
`ifdef LDPC_ENC_PARALLEL_OUT_EN
  ,
  output logic [N-1:0] cw,
  output logic         cw_valid
`endif
);

  localparam int M = N - K;
  localparam logic [4:0] K_LAST = 5'(K - 1);
  localparam logic [4:0] M_TERM = 5'(M);
  localparam logic [4:0] N_LAST = 5'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t       state, state_nxt;
  logic [4:0]   number_nxt;
  logic [4:0]   rom_addr_nxt;
  logic [K-1:0] info, info_nxt;
  logic [M-1:0] parity, parity_nxt;
  logic [4:0]   par_idx;
  logic [31:0]  word_nxt;
  logic         din_ready_nxt, dout_nxt, dout_valid_nxt, dout_last_nxt;
  logic         busy_nxt, done_nxt;
  logic         calc_end;

  always_comb begin
    state_nxt    = state;
    number_nxt   = number;
    info_nxt     = info;
    parity_nxt   = parity;
    rom_addr_nxt = rom_addr;
    done_nxt     = 1'b0;
    calc_end     = 1'b0;
    par_idx      = number - 5'd1;

    case (state)
      IDLE: begin
        if (encode) begin
          state_nxt  = LOAD;
          number_nxt = '0;
        end
      end
      LOAD: begin
        if (din_valid) begin
          // Overwrite the addressed bit; info keeps the previous word otherwise.
          info_nxt = (info & ~(K'(1) << number)) | (K'(din) << number);
          if (number == K_LAST) begin
            state_nxt  = CALC;
            number_nxt = '0;
          end else begin
            number_nxt = number + 5'd1;
          end
        end
      end
      CALC: begin
        // rom_data in this cycle belongs to row number-1
        // (one-cycle ROM latency).
        if (number != 5'd0) begin
          parity_nxt = (parity & ~(M'(1) << par_idx)) |
                       (M'(^(rom_data & info)) << par_idx);
        end
        if (number == M_TERM) begin
          state_nxt  = SEND;
          number_nxt = '0;
          calc_end   = 1'b1;
        end else begin
          number_nxt = number + 5'd1;
        end
      end
      SEND: begin
        if (dout_valid && dout_ready) begin
          if (number == N_LAST) begin
            state_nxt  = IDLE;
            number_nxt = '0;
            done_nxt   = 1'b1;
          end else begin
            number_nxt = number + 5'd1;
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        number_nxt = '0;
      end
    endcase

    if (state_nxt == CALC && number_nxt < M_TERM) begin
      rom_addr_nxt = number_nxt;
    end

    // Outputs are registered, so they are derived from next-state values.
    // parity_nxt carries the final parity bit written on the CALC->SEND edge.
    word_nxt       = 32'({parity_nxt, info_nxt});
    din_ready_nxt  = (state_nxt == LOAD);
    dout_valid_nxt = (state_nxt == SEND);
    dout_nxt       = (state_nxt == SEND) ? word_nxt[number_nxt] : 1'b0;
    dout_last_nxt  = (state_nxt == SEND) && (number_nxt == N_LAST);
    busy_nxt       = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      number     <= '0;
      rom_addr   <= '0;
      info       <= '0;
      parity     <= '0;
      din_ready  <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      number     <= number_nxt;
      rom_addr   <= rom_addr_nxt;
      info       <= info_nxt;
      parity     <= parity_nxt;
      din_ready  <= din_ready_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      dout_last  <= dout_last_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

`ifdef LDPC_ENC_PARALLEL_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cw       <= '0;
      cw_valid <= 1'b0;
    end else begin
      cw_valid <= calc_end;
      if (calc_end) begin
        cw <= {parity_nxt, info};
      end
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_enc_cntrl.sv
module tb_ldpc_enc_cntrl;

  localparam int N = 21;
  localparam int K = 11;
  localparam int M = N - K;

  logic         clk = 1'b0;
  logic         rst, encode, din, din_valid, din_ready;
  logic [4:0]   rom_addr, number;
  logic [K-1:0] rom_data = '0;
  logic         dout, dout_valid, dout_ready, dout_last, busy, done;
`ifdef LDPC_ENC_PARALLEL_OUT_EN
  logic [N-1:0] cw;
  logic         cw_valid;
`endif

  logic [K-1:0] rom_mem [M];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  bit           exp_q [$];

  ldpc_enc_cntrl #(.N(N), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .encode     (encode),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done),
    .number     (number)
`ifdef LDPC_ENC_PARALLEL_OUT_EN
    ,
    .cw         (cw),
    .cw_valid   (cw_valid)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // External ROM, one-cycle read latency.
  always @(posedge clk) rom_data <= (rom_addr < 5'(M)) ? rom_mem[rom_addr] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_din_ready"}, din_ready, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_dout_last"}, dout_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_number"}, number, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
`ifdef LDPC_ENC_PARALLEL_OUT_EN
    check({tag, "_cw"}, cw, 0);
    check({tag, "_cw_valid"}, cw_valid, 0);
`endif
  endtask

  task automatic set_rom_identity();
    for (int j = 0; j < M; j++) rom_mem[j] = K'(1) << j;
  endtask

  // One full encode. rst_bit >= 0 aborts with reset while bit rst_bit is offered.
  task automatic run_cw(input logic [K-1:0] info, input bit gap, input bit bp,
                        input int rst_bit, input bit poke_encode);
    logic [M-1:0] par;
    logic [N-1:0] cwe;
    int  i, c0, guard, idx, ph;
    bit  stalled;
    logic held_dout, held_last;

    for (int j = 0; j < M; j++) par[j] = ^(rom_mem[j] & info);
    cwe = {par, info};
    exp_q.delete();
    for (int b = 0; b < N; b++) exp_q.push_back(cwe[b]);

    @(negedge clk); encode = 1'b1; c0 = cyc;
    @(negedge clk); encode = 1'b0;
    check("start_ready", din_ready, 1);
    check("start_busy", busy, 1);

    i = 0; ph = 0; guard = 0;
    while (i < K && guard < 200) begin
      din_valid = !(gap && (ph % 3 == 2));
      din = info[i];
      ph++;
      if (din_valid) begin
        check("load_number", number, i);
        i++;
      end
      @(negedge clk); guard++;
    end
    check("load_count", i, K);
    check("calc_ready_low", din_ready, 0);

    // Garbage on din during CALC must be ignored.
    din_valid = 1'b1; din = 1'b1;
    if (poke_encode) encode = 1'b1;
    @(negedge clk); encode = 1'b0;
    guard = 0;
    while (!dout_valid && guard < 50) begin @(negedge clk); guard++; end
    din_valid = 1'b0;
    check("send_reached", dout_valid, 1);
    if (!gap) check("send_start_cyc", cyc - c0, 1 + K + M + 1);
`ifdef LDPC_ENC_PARALLEL_OUT_EN
    check("cw_valid_first", cw_valid, 1);
    check("cw_value", cw, cwe);
`endif

    idx = 0; ph = 0; stalled = 0; guard = 0;
    while (idx < N && guard < 400) begin
      if (rst_bit == idx) begin
        rst = 1'b1; dout_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        check_reset("midsend");
        for (int w = 0; w < 4; w++) begin
          @(negedge clk);
          check("midsend_no_done", done, 0);
        end
        return;
      end
      dout_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
`ifdef LDPC_ENC_PARALLEL_OUT_EN
      if (ph == 1) check("cw_valid_once", cw_valid, 0);
`endif
      ph++;
      if (stalled) begin
        check("stall_dout", dout, held_dout);
        check("stall_last", dout_last, held_last);
      end
      if (dout_ready) begin
        check("send_valid", dout_valid, 1);
        check("bit", dout, exp_q.pop_front());
        check("last", dout_last, idx == N - 1);
        idx++;
        stalled = 0;
      end else begin
        stalled = 1; held_dout = dout; held_last = dout_last;
      end
      @(negedge clk); guard++;
    end
    dout_ready = 1'b0;
    check("send_count", idx, N);
    check("done_pulse", done, 1);
    check("done_not_valid", dout_valid, 0);
    check("done_idle", busy, 0);
    if (!gap && !bp) check("latency", cyc - c0, 1 + K + (M + 1) + N);
`ifdef LDPC_ENC_PARALLEL_OUT_EN
    check("cw_hold", cw, cwe);
`endif
    @(negedge clk);
    check("done_once", done, 0);
  endtask

  initial begin
    rst = 1'b1; encode = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    set_rom_identity();
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Zero codeword with identity ROM.
    run_cw(11'h000, 0, 0, -1, 0);
    // Nonzero parity: 0x555 -> parity 0x155, cw 0x0AAD55.
    run_cw(11'h555, 0, 0, -1, 0);
    // Backpressure and gapped din.
    run_cw(11'h555, 1, 1, -1, 0);

    // Random ROM and info, encode poked during CALC.
    for (int j = 0; j < M; j++) rom_mem[j] = K'($urandom);
    run_cw(K'($urandom), 0, 0, -1, 1);
    repeat (5) @(negedge clk);
    check("no_rerun", busy, 0);
    run_cw(K'($urandom), 1, 1, -1, 0);

    // Reset mid-SEND, then a fresh run.
    set_rom_identity();
    run_cw(11'h555, 0, 0, 7, 0);
    run_cw(11'h3A6, 0, 0, -1, 0);

    // Reset from the middle of CALC (rom_addr nonzero).
    @(negedge clk); encode = 1'b1;
    @(negedge clk); encode = 1'b0; din_valid = 1'b1; din = 1'b1;
    repeat (K + 5) @(negedge clk);
    din_valid = 1'b0;
    check("calc_busy", busy, 1);
    rst = 1'b1; encode = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("calc_rst");
    rst = 1'b0; encode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ldpc_enc_cntrl.md
# ldpc_enc_cntrl

Sequencing controller for the small-code LDPC encoder; it is the transmit-side counterpart of the decoder control path. It accepts K information bits serially and computes M parity bits as XOR-masked products against a parity-generator ROM, one row per cycle. It then streams the systematic N-bit codeword out serially under valid/ready flow control. The parity-generator ROM (one-cycle read latency) sits outside this block.

## Interface
- N, 21, codeword length in bits (N ≤ 32).
- K, 11, information bits; M = N−K parity bits (derived localparam, 10 by default).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- encode  in  1  start request; sampled only in IDLE.
- din  in  1  serial information bit.
- din_valid  in  1  din qualifier.
- din_ready  out  1  high only in LOAD.
- rom_addr  out  5  parity-generator row index, 0..M−1.
- rom_data  in  K  row contents; valid the cycle after rom_addr is driven.
- dout  out  1  serial codeword bit.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  downstream accept.
- dout_last  out  1  high with the final codeword bit (index N−1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last bit transfers.
- number  out  5  current bit or row index within the active state.

## Operation
- States are IDLE, LOAD, CALC and SEND. All outputs, the info register (K bits), the parity register (M bits) and number are registered.
- **IDLE**
  - encode=1 moves the block to LOAD with number=0.
  - encode is ignored in every other state; no queuing.
- **LOAD**
  - din_ready=1.
  - Each cycle with din_valid=1 does info[number] ← din and number ← number+1.
  - The transfer with number=K−1 moves the block to CALC with number=0, and din_ready drops in the next cycle.
- **CALC**
  - rom_addr=number on cycles 0..M−1.
  - On cycles 1..M, parity[number−1] ← ^(rom_data & info).
  - After cycle M, the block enters SEND with number=0.
  - CALC lasts exactly M+1 cycles, and din_valid is ignored throughout.
- **SEND**
  - dout_valid=1.
  - dout = info[number] for number<K, and parity[number−K] otherwise.
  - number advances only when dout_valid&dout_ready.
  - dout_last = (number==N−1).
  - The transfer at N−1 returns the block to IDLE, with done=1 for exactly that next cycle.
- Arithmetic and width rules:
  - number is 5 bits and never wraps past N−1; its terminal compare is against K−1, M or N−1 as the state requires.
  - rom_addr holds its last value outside CALC.
- Reset values: state=IDLE, din_ready=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0, number=0, rom_addr=0, info=0, parity=0.
- Reset asserted mid-operation (any state) forces all reset values on the next edge. A partially sent codeword is abandoned, and done is not pulsed.
- If rst and encode are high together, rst wins.

## Timing
- Start: encode high at edge t → LOAD and din_ready=1 from t+1.
- With din_valid held high, LOAD lasts K cycles, CALC M+1 cycles, and SEND N cycles with dout_ready held high.
- Minimum encode-to-done latency is 1+K+(M+1)+N cycles (= 44 at the defaults).
- dout and dout_last are stable while dout_valid=1 and dout_ready=0.
- done and dout_valid are never high in the same cycle.

## Configuration
- LDPC_ENC_PARALLEL_OUT_EN
  - Defined: adds the output ports cw [N−1:0] = {parity, info} (parity in the MSBs) and cw_valid, a one-cycle pulse on the first SEND cycle. cw holds its value until the next CALC completes. The serial port behaves identically with or without the macro.
  - Undefined: neither port nor its logic exists.

## Test plan
- **Reset values:** assert rst for 2 cycles from random state → every output equals its reset value listed above; busy=0.
- **Zero codeword:** encode, load 11 zero bits, ROM row j = 1<<j → 21 serial zeros, dout_last on the 21st, done 1 cycle later, total 44 cycles.
- **Nonzero parity:** info=11'h555 (bit 0 first), ROM row j = 1<<j → parity=10'h155; serial stream shows info bits 0..10, then parity bits 0..9.
- **Backpressure:** as in the nonzero-parity case, with dout_ready toggling 1,0,0,1 repeating and din_valid gapped every third cycle → identical bit sequence, dout stable while stalled, no duplicated or dropped bits.
- **Reset mid-SEND and ignored encode:**
  - encode pulsed during CALC → ignored, no second run.
  - rst at SEND bit 7 → IDLE next cycle, no done.
  - A fresh encode afterwards → correct full codeword.
- **Macro defined:** as in the nonzero-parity case → cw=21'h0AAD55 with one cw_valid pulse on the first SEND cycle; serial output unchanged.
